cpu_mem_bus_arbiter: RTL and testbench

CPU_MEM_BUS_ARBITER -- requirements
Module: cpu_mem_bus_arbiter

---
 rtl/cpu_mem_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cpu_mem_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bus_arbiter.sv
// Two-requester (D-cache / I-cache) arbiter onto a single-outstanding memory bus.
// Optional macro CPU_MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; default is fixed D-cache priority.
`ifndef LINE_WIDTH
`define LINE_WIDTH 128
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module cpu_mem_bus_arbiter #(
    parameter int LINE_WIDTH      = `LINE_WIDTH,
    parameter int LINE_ADDR_WIDTH = `PHYSICAL_ADDR_WIDTH - $clog2(`LINE_WIDTH / `BYTE_WIDTH)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       dc_req_read,
    input  logic                       dc_req_write,
    input  logic [LINE_ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [LINE_WIDTH-1:0]      dc_req_data,
    input  logic                       ic_req_read,
    input  logic                       ic_req_write,
    input  logic [LINE_ADDR_WIDTH-1:0] ic_req_addr,
    input  logic [LINE_WIDTH-1:0]      ic_req_data,
    output logic                       dc_available,
    output logic                       ic_available,
    output logic                       dc_resp_valid,
    output logic                       ic_resp_valid,
    output logic [LINE_ADDR_WIDTH-1:0] resp_addr,
    output logic [LINE_WIDTH-1:0]      resp_data,
    output logic                       mem_req_valid,
    output logic                       mem_req_write,
    output logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0]      mem_req_data,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    input  logic [LINE_ADDR_WIDTH-1:0] mem_resp_addr,
    input  logic [LINE_WIDTH-1:0]      mem_resp_data,
    output logic                       busy,
    output logic                       err_unexpected_resp
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic OWNER_DC = 1'b0;
    localparam logic OWNER_IC = 1'b1;

    state_t                     state_r;
    logic                       avail_r;
    logic                       owner_r;
    logic                       mem_req_valid_r;
    logic                       mem_req_write_r;
    logic [LINE_ADDR_WIDTH-1:0] mem_req_addr_r;
    logic [LINE_WIDTH-1:0]      mem_req_data_r;
    logic                       busy_r;
    logic                       err_r;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
    logic                       last_ic_r;
`endif

    logic                       dc_req_s;
    logic                       ic_req_s;
    logic                       grant_s;
    logic                       grant_ic_s;
    logic                       sel_write_s;
    logic [LINE_ADDR_WIDTH-1:0] sel_addr_s;
    logic [LINE_WIDTH-1:0]      sel_data_s;

    // Arbitration between the two requesters and selection of the winner's payload
    always_comb begin
        dc_req_s    = dc_req_read | dc_req_write;
        ic_req_s    = ic_req_read | ic_req_write;
        grant_s     = dc_req_s | ic_req_s;
        grant_ic_s  = 1'b0;
        if (dc_req_s && ic_req_s) begin
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
            // Tie goes to whoever was not granted last
            grant_ic_s = ~last_ic_r;
`else
            grant_ic_s = 1'b0;
`endif
        end else if (ic_req_s) begin
            grant_ic_s = 1'b1;
        end else begin
            grant_ic_s = 1'b0;
        end
        if (grant_ic_s) begin
            sel_write_s = ic_req_write;
            sel_addr_s  = ic_req_addr;
            sel_data_s  = ic_req_data;
        end else begin
            sel_write_s = dc_req_write;
            sel_addr_s  = dc_req_addr;
            sel_data_s  = dc_req_data;
        end
    end

    // Transaction FSM with registered bus-side outputs and sticky error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            avail_r         <= 1'b1;
            owner_r         <= OWNER_DC;
            mem_req_valid_r <= 1'b0;
            mem_req_write_r <= 1'b0;
            mem_req_addr_r  <= {LINE_ADDR_WIDTH{1'b0}};
            mem_req_data_r  <= {LINE_WIDTH{1'b0}};
            busy_r          <= 1'b0;
            err_r           <= 1'b0;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
            last_ic_r       <= 1'b1;
`endif
        end else begin
            if (mem_resp_valid && (state_r != ST_WAIT)) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        owner_r         <= grant_ic_s ? OWNER_IC : OWNER_DC;
                        mem_req_valid_r <= 1'b1;
                        mem_req_write_r <= sel_write_s;
                        mem_req_addr_r  <= sel_addr_s;
                        mem_req_data_r  <= sel_data_s;
                        busy_r          <= 1'b1;
                        avail_r         <= 1'b0;
                        state_r         <= ST_ISSUE;
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
                        last_ic_r       <= grant_ic_s;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        if (mem_req_write_r) begin
                            busy_r  <= 1'b0;
                            avail_r <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        busy_r  <= 1'b0;
                        avail_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_valid_r <= 1'b0;
                    busy_r          <= 1'b0;
                    avail_r         <= 1'b1;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

    // Availability is forced low while reset is held so requesters never see a grant window then
    assign dc_available        = avail_r & reset;
    assign ic_available        = avail_r & reset;
    assign mem_req_valid       = mem_req_valid_r;
    assign mem_req_write       = mem_req_write_r;
    assign mem_req_addr        = mem_req_addr_r;
    assign mem_req_data        = mem_req_data_r;
    assign busy                = busy_r;
    assign err_unexpected_resp = err_r;
    assign resp_addr           = mem_resp_addr;
    assign resp_data           = mem_resp_data;
    assign dc_resp_valid       = (state_r == ST_WAIT) && mem_resp_valid && (owner_r == OWNER_DC);
    assign ic_resp_valid       = (state_r == ST_WAIT) && mem_resp_valid && (owner_r == OWNER_IC);

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// Self-checking bench for cpu_mem_bus_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_cpu_mem_bus_arbiter;

    localparam int LW = 128;
    localparam int AW = 28;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          dc_req_read = 1'b0, dc_req_write = 1'b0;
    logic [AW-1:0] dc_req_addr = '0;
    logic [LW-1:0] dc_req_data = '0;
    logic          ic_req_read = 1'b0, ic_req_write = 1'b0;
    logic [AW-1:0] ic_req_addr = '0;
    logic [LW-1:0] ic_req_data = '0;
    logic          mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [AW-1:0] mem_resp_addr = '0;
    logic [LW-1:0] mem_resp_data = '0;
    logic          dc_available, ic_available, dc_resp_valid, ic_resp_valid;
    logic [AW-1:0] resp_addr, mem_req_addr;
    logic [LW-1:0] resp_data, mem_req_data;
    logic          mem_req_valid, mem_req_write, busy, err_unexpected_resp;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: one outstanding transaction, its phase and owner
    bit            m_busy, m_accepted, m_owner_ic, m_write, m_err, m_last_ic;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_data;

    cpu_mem_bus_arbiter #(.LINE_WIDTH(LW), .LINE_ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .dc_req_read(dc_req_read), .dc_req_write(dc_req_write),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
        .ic_req_read(ic_req_read), .ic_req_write(ic_req_write),
        .ic_req_addr(ic_req_addr), .ic_req_data(ic_req_data),
        .dc_available(dc_available), .ic_available(ic_available),
        .dc_resp_valid(dc_resp_valid), .ic_resp_valid(ic_resp_valid),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_addr(mem_resp_addr),
        .mem_resp_data(mem_resp_data),
        .busy(busy), .err_unexpected_resp(err_unexpected_resp)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_accepted = 1'b0; m_err = 1'b0; m_last_ic = 1'b1;
    endtask

    task automatic clear_inputs();
        dc_req_read = 1'b0; dc_req_write = 1'b0; ic_req_read = 1'b0; ic_req_write = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = m_busy && !m_accepted;
        chk("dc_available", dc_available, reset && !m_busy);
        chk("ic_available", ic_available, reset && !m_busy);
        chk("busy", busy, m_busy);
        chk("mem_req_valid", mem_req_valid, exp_req);
        if (exp_req) begin
            chk("mem_req_write", mem_req_write, m_write);
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk("mem_req_data", mem_req_data, m_data);
        end
        chk("dc_resp_valid", dc_resp_valid, m_busy && m_accepted && mem_resp_valid && !m_owner_ic);
        chk("ic_resp_valid", ic_resp_valid, m_busy && m_accepted && mem_resp_valid && m_owner_ic);
        chk("resp_addr", resp_addr, mem_resp_addr);
        chk("resp_data", resp_data, mem_resp_data);
        chk("err", err_unexpected_resp, m_err);
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_update();
        bit dreq, ireq, win_ic;
        if (!reset) return;
        if (mem_resp_valid && !(m_busy && m_accepted)) m_err = 1'b1;
        if (!m_busy) begin
            dreq = dc_req_read | dc_req_write;
            ireq = ic_req_read | ic_req_write;
            if (dreq || ireq) begin
                if (dreq && ireq) begin
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
                    win_ic = !m_last_ic;
`else
                    win_ic = 1'b0;
`endif
                end else begin
                    win_ic = ireq;
                end
                m_busy = 1'b1; m_accepted = 1'b0; m_owner_ic = win_ic; m_last_ic = win_ic;
                m_write = win_ic ? ic_req_write : dc_req_write;
                m_addr  = win_ic ? ic_req_addr : dc_req_addr;
                m_data  = win_ic ? ic_req_data : dc_req_data;
            end
        end else if (!m_accepted) begin
            if (mem_req_ready) begin
                if (m_write) m_busy = 1'b0;
                else m_accepted = 1'b1;
            end
        end else if (mem_resp_valid) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        model_update();
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [AW-1:0] tie_addr [3];
    logic [AW-1:0] exp_tie  [3];

    initial begin
        model_reset();
        @(negedge clock);
        @(negedge clock);
        // Reset values while reset is held
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_req_write", mem_req_write, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr, '0);
        chk("rst_mem_req_data", mem_req_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_unexpected_resp, 1'b0);
        chk("rst_dc_available", dc_available, 1'b0);
        chk("rst_ic_available", ic_available, 1'b0);
        reset = 1'b1;
        #1;
        chk("rel_dc_available", dc_available, 1'b1);
        chk("rel_ic_available", ic_available, 1'b1);
        step();

        // D-cache read, zero-wait memory
        dc_req_read = 1'b1; dc_req_addr = 28'h10;
        step();
        clear_inputs(); mem_req_ready = 1'b1;
        chk("rd_mem_req_valid", mem_req_valid, 1'b1);
        chk("rd_mem_req_addr", mem_req_addr, 28'h10);
        step();
        clear_inputs(); mem_resp_valid = 1'b1; mem_resp_addr = 28'h10; mem_resp_data = {16{8'hA5}};
        #1;
        chk("rd_dc_resp_valid", dc_resp_valid, 1'b1);
        chk("rd_ic_resp_valid", ic_resp_valid, 1'b0);
        chk("rd_resp_data", resp_data, {16{8'hA5}});
        step();
        clear_inputs();
        chk("rd_back_idle", dc_available, 1'b1);
        chk("rd_dc_resp_gone", dc_resp_valid, 1'b0);

        // I-cache write with memory stalling four cycles
        ic_req_write = 1'b1; ic_req_addr = 28'h3; ic_req_data = {4{32'hDEADBEEF}};
        step();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            chk("wr_hold_valid", mem_req_valid, 1'b1);
            chk("wr_hold_addr", mem_req_addr, 28'h3);
            chk("wr_hold_data", mem_req_data, {4{32'hDEADBEEF}});
            step();
        end
        mem_req_ready = 1'b1;
        step();
        clear_inputs();
        chk("wr_idle", ic_available, 1'b1);
        chk("wr_no_resp", ic_resp_valid, 1'b0);

        // Three back-to-back ties; the winner is read from the issued address
        for (int t = 0; t < 3; t++) begin
            dc_req_read = 1'b1; dc_req_addr = 28'hD00;
            ic_req_read = 1'b1; ic_req_addr = 28'h100;
            step();
            clear_inputs(); mem_req_ready = 1'b1;
            tie_addr[t] = mem_req_addr;
            step();
            clear_inputs(); mem_resp_valid = 1'b1;
            step();
            clear_inputs();
        end
`ifdef CPU_MEM_ARB_ROUND_ROBIN_EN
        exp_tie[0] = 28'hD00; exp_tie[1] = 28'h100; exp_tie[2] = 28'hD00;
`else
        exp_tie[0] = 28'hD00; exp_tie[1] = 28'hD00; exp_tie[2] = 28'hD00;
`endif
        for (int t = 0; t < 3; t++) chk("tie_winner", tie_addr[t], exp_tie[t]);

        // Requests raised during WAIT are ignored until the bus is free again
        dc_req_read = 1'b1; dc_req_addr = 28'h55;
        step();
        clear_inputs(); mem_req_ready = 1'b1;
        step();
        clear_inputs(); ic_req_read = 1'b1; ic_req_addr = 28'h77;
        for (int i = 0; i < 3; i++) begin
            chk("wait_no_req", mem_req_valid, 1'b0);
            step();
        end
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        step();
        clear_inputs();
        chk("wait_late_grant_valid", mem_req_valid, 1'b1);
        chk("wait_late_grant_addr", mem_req_addr, 28'h77);
        mem_req_ready = 1'b1;
        step();
        clear_inputs();

        // Asynchronous reset while in WAIT, then a stray response
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_mem_req_valid", mem_req_valid, 1'b0);
        chk("arst_mem_req_addr", mem_req_addr, '0);
        chk("arst_available", dc_available, 1'b0);
        check_outputs();
        @(negedge clock);
        reset = 1'b1;
        step();
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk("stray_resp_err", err_unexpected_resp, 1'b1);
        step();

        // Randomised traffic from a fresh reset
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            dc_req_read   = ($urandom % 4) == 0;
            dc_req_write  = ($urandom % 5) == 0;
            ic_req_read   = ($urandom % 4) == 0;
            ic_req_write  = ($urandom % 6) == 0;
            dc_req_addr   = AW'($urandom);
            ic_req_addr   = AW'($urandom);
            dc_req_data   = {$urandom, $urandom, $urandom, $urandom};
            ic_req_data   = {$urandom, $urandom, $urandom, $urandom};
            mem_req_ready = $urandom % 2;
            mem_resp_valid = (m_busy && m_accepted) ? (($urandom % 3) == 0) : (($urandom % 150) == 0);
            mem_resp_addr = AW'($urandom);
            mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
